// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and constants for the elastic pipeline stages.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

    typedef struct packed {
        logic       reg_wr;
        logic       mem_wr;
        logic       mem_rd;
        logic [2:0] mem_mask;
        logic [1:0] sel_wb;
    } ex_mem_ctrl_t;

    typedef struct packed {
        logic [31:0] alu_o;
        logic [31:0] wr_data;
        logic [4:0]  rd;
        logic [31:0] pc4;
    } ex_mem_data_t;

    localparam ex_mem_ctrl_t BUBBLE_CTRL = '0;
    localparam int unsigned  C_CTRL_W    = $bits(ex_mem_ctrl_t);
    localparam int unsigned  C_DATA_W    = $bits(ex_mem_data_t);

endpackage
`default_nettype wire

// File: rtl/pipe_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : pipe_sat_counter
// Description : Saturating up-counter with synchronous clear (clear wins).
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_elastic.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_elastic
// Description : Elastic valid/ready pipeline register with optional skid entry.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W      = C_CTRL_W,
    parameter int unsigned DATA_W      = C_DATA_W,
    parameter bit          SKID        = 1'b1,
    parameter bit          ZERO_BUBBLE = 1'b1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    localparam logic [CTRL_W-1:0] C_BUBBLE = CTRL_W'(BUBBLE_CTRL);

    stage_state_t      r_state;
    stage_state_t      w_state_nxt;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_load_main_in;
    logic              w_load_main_skid;
    logic              w_load_skid;
    logic              w_in_ready_skid;
    logic              w_in_ready_single;

    assign out_valid = (r_state != EMPTY) & ~flush;

    // The skid variant depends only on registered state; the single-entry
    // variant has to look through to out_ready to keep full throughput.
    assign w_in_ready_skid   = (r_state != FULL) & ~flush & ~rst;
    assign w_in_ready_single = (~out_valid | out_ready) & ~flush & ~rst;
    assign in_ready          = SKID ? w_in_ready_skid : w_in_ready_single;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt    = ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_load_main_in = 1'b1;
                    end else if (w_in_fire && SKID) begin
                        w_state_nxt = FULL;
                        w_load_skid = 1'b1;
                    end else if (w_out_fire) begin
                        w_state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (w_out_fire) begin
                        w_state_nxt      = ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_main_ctrl <= '0;
            r_main_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (flush) begin
                r_main_ctrl <= '0;
                r_main_data <= '0;
            end else if (w_load_main_in) begin
                r_main_ctrl <= in_ctrl;
                r_main_data <= in_data;
            end else if (w_load_main_skid) begin
                r_main_ctrl <= w_skid_ctrl;
                r_main_data <= w_skid_data;
            end
        end
    end

    generate
        if (SKID) begin : g_skid
            logic [CTRL_W-1:0] r_skid_ctrl;
            logic [DATA_W-1:0] r_skid_data;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_skid_ctrl <= '0;
                    r_skid_data <= '0;
                end else if (flush) begin
                    r_skid_ctrl <= '0;
                    r_skid_data <= '0;
                end else if (w_load_skid) begin
                    r_skid_ctrl <= in_ctrl;
                    r_skid_data <= in_data;
                end
            end

            assign w_skid_ctrl = r_skid_ctrl;
            assign w_skid_data = r_skid_data;
        end else begin : g_no_skid
            assign w_skid_ctrl = '0;
            assign w_skid_data = '0;
        end
    endgenerate

    // Outputs come straight from the main entry: no flow-through from in_*.
    assign out_ctrl  = out_valid ? r_main_ctrl : C_BUBBLE;
    assign out_data  = (ZERO_BUBBLE && !out_valid) ? '0 : r_main_data;
    assign occupancy = r_state;

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (out_valid & ~out_ready),
        .i_clr   (stall_clr),
        .o_count (stall_cnt)
    );

    a_no_in_fire_full : assert property (@(posedge clk) disable iff (rst)
        !(w_in_fire && (r_state == FULL)));
    a_bubble_ctrl : assert property (@(posedge clk) disable iff (rst)
        out_valid || (out_ctrl == C_BUBBLE));
    a_no_full_single : assert property (@(posedge clk) disable iff (rst)
        SKID || (r_state != FULL));

endmodule
`default_nettype wire
